uart_tx_scheduler: RTL

Sits between the command/mode front end and the UART transmitter, which it shares between two requesters:
- the normal echo-data stream, written in as bytes;
- rate-change commands, which it acknowledges with a 3-byte message.

It buffers data in a small FIFO. A rate change is applied only after previously queued bytes have left and the transmitter line is idle, so no byte is ever sent at a mixed baud rate.

---
 rtl/uart_tx_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmitter between a buffered echo-data stream and rate-change acknowledgements.
// A rate change waits for the bytes queued before it to leave and for the line to go idle.
module uart_tx_scheduler #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter bit ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iData,
  input  logic       iWRen,
  input  logic       iRATE_REQ,
  input  logic [1:0] iRate,
  input  logic       iCLEAN,
  output logic [7:0] oTX_DATA,
  output logic       oTX_VALID,
  input  logic       iTX_READY,
  input  logic       iTX_IDLE,
  output logic [1:0] oRATE,
  output logic       oRATE_BUSY,
  output logic       oFULL,
  output logic       oEMPTY,
  output logic       oOVF
);

  typedef enum logic [2:0] {IDLE, SEND, DRAIN, APPLY, ACK0, ACK1, ACK2} state_e;

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  state_e      state_q;
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0] count_q, count_d, snap_q, snapAccept;
  logic [7:0]  txData_q;
  logic        txValid_q;
  logic [1:0]  rate_q, reqRate_q;
  logic        busy_q, ovf_q, cleanPend_q;
  logic        full, empty, txFire, flush, pop, wrEn, rateAccept;

  function automatic logic [7:0] rateChar(input logic [1:0] code);
    case (code)
      2'b00:   rateChar = 8'h31;
      2'b01:   rateChar = 8'h35;
      2'b10:   rateChar = 8'h41;
      default: rateChar = 8'h3F;
    endcase
  endfunction

  // The flush wins over a same-cycle write; snap excludes a byte popped on the latch cycle.
  always_comb begin
    full       = (count_q == FullCount);
    empty      = (count_q == '0);
    txFire     = txValid_q && iTX_READY;
    flush      = (state_q == IDLE) && cleanPend_q;
    pop        = ((state_q == IDLE) && !cleanPend_q && !busy_q && !empty) ||
                 ((state_q == DRAIN) && !txValid_q && (snap_q != '0));
    wrEn       = iWRen && !full && !flush;
    rateAccept = iRATE_REQ && !busy_q && (iRate != 2'b11);
    wrPtr_d    = flush ? '0 : wrPtr_q + AW'(wrEn);
    rdPtr_d    = flush ? '0 : rdPtr_q + AW'(pop);
    count_d    = flush ? '0 : count_q + (AW+1)'(wrEn) - (AW+1)'(pop);
    snapAccept = flush ? '0 : count_q - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= iData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      snap_q      <= '0;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      rate_q      <= 2'b00;
      reqRate_q   <= 2'b00;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cleanPend_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      cleanPend_q <= iCLEAN || (cleanPend_q && !flush);
      if (flush)
        ovf_q <= 1'b0;
      else if (iWRen && full)
        ovf_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cleanPend_q) begin
            snap_q <= '0;
          end else if (busy_q) begin
            state_q <= DRAIN;
          end else if (!empty) begin
            txData_q  <= mem_q[rdPtr_q];
            txValid_q <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (txFire) begin
            txValid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        DRAIN: begin
          if (txValid_q) begin
            if (txFire) begin
              txValid_q <= 1'b0;
              snap_q    <= snap_q - 1'b1;
            end
          end else if (snap_q != '0) begin
            txData_q  <= mem_q[rdPtr_q];
            txValid_q <= 1'b1;
          end else begin
            state_q <= APPLY;
          end
        end
        APPLY: begin
          if (iTX_IDLE && !txValid_q) begin
            rate_q <= reqRate_q;
            if (ACK_EN) begin
              txData_q  <= 8'h52;
              txValid_q <= 1'b1;
              state_q   <= ACK0;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        ACK0: begin
          if (txFire) begin
            txData_q <= rateChar(rate_q);
            state_q  <= ACK1;
          end
        end
        ACK1: begin
          if (txFire) begin
            txData_q <= 8'h0A;
            state_q  <= ACK2;
          end
        end
        ACK2: begin
          if (txFire) begin
            txValid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Acceptance needs busy low, so it never collides with the DRAIN/ACK updates above.
      if (rateAccept) begin
        busy_q    <= 1'b1;
        reqRate_q <= iRate;
        snap_q    <= snapAccept;
      end
    end
  end

  assign oTX_DATA   = txData_q;
  assign oTX_VALID  = txValid_q;
  assign oRATE      = rate_q;
  assign oRATE_BUSY = busy_q;
  assign oFULL      = full;
  assign oEMPTY     = empty;
  assign oOVF       = ovf_q;

endmodule
